lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
- Load/store initiator between the RISC-V execute stage and the word-organised data memory.
- The data memory is 1024 x 32, with a combinational read and a write that happens when MemW is high at the CLK posedge. It has no byte enables.
- This block turns byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
- Sub-word stores are done as read-modify-write. Load data is sign- or zero-extended.
- Misaligned and illegal accesses are reported to the pipeline instead of being issued to memory.

Parameters:
- MEM_AW, 10, word-address width of the data memory. Memory depth is 2^MEM_AW words.
- XLEN, 32, data and address width. Fixed at 32; other values are unsupported.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse when the request completes.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; misaligned or illegal access.
- mem_addr  out  MEM_AW  word address, equal to req_addr[MEM_AW+1:2].
- mem_wdata  out  32  merged write word.
- mem_we  out  1  memory write strobe (drives MemW).
- mem_rdata  in  32  memory read data, combinational from mem_addr.

Behaviour:
- Reset (async, RST_N=0):
  - state goes to IDLE.
  - req_ready=1; resp_valid=0, resp_err=0.
  - resp_rdata=0, mem_addr=0, mem_wdata=0.
  - mem_we=0 immediately, including mid-operation. The current request is dropped with no response.
- Accept: a request is accepted on a posedge with req_valid && req_ready. addr, funct3, store and wdata are registered. req_ready=0 until the block returns to IDLE.
- States:
  - IDLE: on accept, go to ERR if the request is illegal. Otherwise go to WR for SW, or RD for all other requests.
  - RD: drive mem_addr; mem_we=0. At the posedge, capture mem_rdata. A load then goes to RESP with the extended data. SB/SH go to WR with the merged word.
  - WR: mem_we=1 for exactly one cycle, with mem_addr and mem_wdata stable. Then go to RESP.
  - RESP: resp_valid=1, resp_err=0. Then go to IDLE.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0. No memory access. Then go to IDLE.
- Latency from the accept edge to the resp_valid cycle:
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- The next request can be accepted the cycle after resp_valid, i.e. when IDLE is re-entered.
- Illegal requests:
  - funct3 in {011, 110, 111}.
  - store with funct3 100 or 101.
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - B and H are sign-extended from bit 7 or bit 15. BU and HU are zero-extended.
- Store merge:
  - SB replaces byte addr[1:0] of the read word with req_wdata[7:0].
  - SH replaces half addr[1] with req_wdata[15:0].
  - SW writes req_wdata unchanged.
- Address bits above MEM_AW+1 are ignored, so the address wraps modulo memory size unless the optional feature is enabled.
- mem_we is never high outside WR.
- mem_addr holds its value in IDLE. Outputs are registered.
- req_valid held high during a busy state is ignored; there is no queueing.

Optional Feature:
- Macro: LSU_RANGE_CHECK_EN.
- Defined: a request with req_addr[31:MEM_AW+2] != 0 is illegal and goes to ERR, with no memory access.
- Undefined: upper address bits are ignored and the access wraps.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum IDLE/RD/WR/RESP/ERR.
  - XLEN.
- Sub-module lsu_lane_align, purely combinational, inside lsu_mem_ctrl:
  - Load: takes word, funct3 and addr[1:0]; returns the extended value.
  - Store: takes old word, wdata, funct3 and addr[1:0]; returns the merged word.

Test Plan:
- Memory word 5 = 0x8899AABB. LB addr 0x15 -> resp_rdata 0xFFFFFFAA, 2 cycles after accept. LBU same address -> 0x000000AA.
- Memory word 5 = 0x8899AABB. SB addr 0x16, wdata 0x123 -> one mem_we pulse, mem_addr=5, mem_wdata=0x8823AABB, resp_valid 3 cycles after accept, resp_err=0.
- SW addr 0x20, wdata 0xDEADBEEF; then LH addr 0x22 -> 0xFFFFDEAD; then LHU addr 0x20 -> 0x0000BEEF.
- LW addr 0x41, SH addr 0x03, and funct3=011 -> each gives resp_err=1, resp_rdata=0 one cycle after accept, mem_we never asserted.
- Assert RST_N=0 during the WR cycle of an SB -> mem_we drops immediately, no resp_valid, req_ready=1 after release, next LW completes normally.
- With LSU_RANGE_CHECK_EN, LW addr 0x1000 -> resp_err=1. Without it, the same LW returns word 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the request legality check.
package lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } state_e;

    // Unsigned stores and misaligned halves/words never reach memory.
    function automatic logic req_illegal(input logic       store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] off);
        logic bad;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = off[0];
            F3_W:    bad = (off != 2'b00);
            F3_BU:   bad = store;
            F3_HU:   bad = store | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte/half lane steering: extends load data out of a memory
// word and merges sub-word store data into the old word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] ld_word,
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    input  logic [XLEN-1:0] st_old,
    input  logic [XLEN-1:0] st_wdata,
    output logic [XLEN-1:0] ld_data,
    output logic [XLEN-1:0] st_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = ld_word[{byte_off, 3'b000} +: 8];
        half_sel = byte_off[1] ? ld_word[31:16] : ld_word[15:0];

        ld_data = ld_word;
        case (funct3)
            F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data = {24'h000000, byte_sel};
            F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ld_data = {16'h0000, half_sel};
            default: ld_data = ld_word;
        endcase
    end

    always_comb begin
        st_word = st_old;
        case (funct3)
            F3_B: st_word[{byte_off, 3'b000} +: 8] = st_wdata[7:0];
            F3_H: begin
                if (byte_off[1]) begin
                    st_word[31:16] = st_wdata[15:0];
                end else begin
                    st_word[15:0] = st_wdata[15:0];
                end
            end
            F3_W:    st_word = st_wdata;
            default: st_word = st_old;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a word-organised data memory without byte enables.
// Optional macro LSU_RANGE_CHECK_EN turns out-of-range addresses into errors.
module lsu_mem_ctrl #(
    parameter int MEM_AW = 10,
    parameter int XLEN   = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic              mem_we,
    input  logic [XLEN-1:0]   mem_rdata
);

    import lsu_pkg::*;

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;

    logic [1:0]        off_q, off_d;
    logic [2:0]        f3_q, f3_d;
    logic              store_q, store_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;

    logic              accept;
    logic              illegal;
    logic [XLEN-1:0]   ld_data;
    logic [XLEN-1:0]   st_word;

    assign accept = req_valid && req_ready_q;

`ifdef LSU_RANGE_CHECK_EN
    assign illegal = req_illegal(req_store, req_funct3, req_addr[1:0]) ||
                     (req_addr[XLEN-1:MEM_AW+2] != '0);
`else
    // Upper address bits are deliberately dropped so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[XLEN-1:MEM_AW+2];
    assign illegal = req_illegal(req_store, req_funct3, req_addr[1:0]);
`endif

    lsu_lane_align u_lane_align (
        .ld_word  (mem_rdata),
        .funct3   (f3_q),
        .byte_off (off_q),
        .st_old   (mem_rdata),
        .st_wdata (wdata_q),
        .ld_data  (ld_data),
        .st_word  (st_word)
    );

    // Outputs are registered, so each is computed for the state being entered.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        off_d        = off_q;
        f3_d         = f3_q;
        store_d      = store_q;
        wdata_d      = wdata_q;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    off_d       = req_addr[1:0];
                    f3_d        = req_funct3;
                    store_d     = req_store;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    if (illegal) begin
                        state_d      = ERR;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_store && (req_funct3 == F3_W)) begin
                        state_d     = WR;
                        mem_addr_d  = req_addr[MEM_AW+1:2];
                        mem_wdata_d = req_wdata;
                        mem_we_d    = 1'b1;
                    end else begin
                        state_d    = RD;
                        mem_addr_d = req_addr[MEM_AW+1:2];
                    end
                end
            end
            RD: begin
                if (store_q) begin
                    state_d     = WR;
                    mem_wdata_d = st_word;
                    mem_we_d    = 1'b1;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ld_data;
                end
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP, ERR: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
        end
    end

    // Request capture is pure datapath and only matters after an accept.
    always_ff @(posedge CLK) begin
        off_q   <= off_d;
        f3_q    <= f3_d;
        store_q <= store_d;
        wdata_q <= wdata_d;
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;

endmodule
